code_memory_loader: RTL and testbench
=====================================

Name: code_memory_loader

Overview:
- Program memory responder for the fetch stage: it answers the fetch stage's code_addr with code_word.
- It also provides a byte-stream loader that fills the memory before execution.
- It holds the processor in reset until a complete program image has been written, then releases it.
- It sits between the external host link (UART/SPI byte receiver) and processor stage 1.

Parameters:
ADDR_SIZE, 18, width of the fetch address bus
WORD_SIZE, 18, width of one code word
MEM_ADDR_BITS, 10, log2 of memory depth (DEPTH = 2^MEM_ADDR_BITS words)

Ports:
clock  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
code_addr  input  ADDR_SIZE  fetch address from stage 1
code_word  output  WORD_SIZE  registered instruction word for code_addr
load_start  input  1  begin a new image load (one-cycle pulse)
byte_in  input  8  loader data byte
byte_valid  input  1  byte_in valid this cycle
byte_ready  output  1  loader accepts a byte this cycle
load_done  output  1  one-cycle pulse: image fully written
overflow  output  1  sticky: image word count exceeded DEPTH
cpu_reset  output  1  reset request to the processor pipeline

Behaviour:
- Reset values:
  - state = WAIT
  - code_word = 0, byte_ready = 0, load_done = 0, overflow = 0, cpu_reset = 1.
  - Memory contents are not cleared.
- States:
  - WAIT: no image loaded.
  - HDR: collecting 3 header bytes.
  - DATA: collecting word bytes.
  - RUN: program executing.
- A byte transfer occurs on a cycle where byte_valid && byte_ready. byte_ready = 1 exactly in HDR and DATA.
- Byte assembly, little-endian, 3 bytes per 18-bit value:
  - b0 -> bits[7:0], b1 -> bits[15:8], b2[1:0] -> bits[17:16].
  - b2[7:2] is ignored.
  - A 2-bit byte index counts 0,1,2,0...
- Transitions:
  - WAIT/RUN -> HDR on load_start. On entry: byte index = 0, overflow cleared, cpu_reset = 1.
  - load_start in HDR or DATA restarts HDR and discards partial data.
  - HDR: 3 transfers form word_count (18 bit).
    - If word_count == 0: go to RUN, pulse load_done on the next cycle.
    - Otherwise: write address = 0, go to DATA.
  - DATA: on each third byte, write the assembled word to mem[write address], increment the write address, decrement the remaining count.
    - Write addresses >= DEPTH are not written, overflow is set to 1, and the bytes are still consumed.
    - When the last word's third byte transfers: go to RUN, load_done = 1 for exactly the following cycle.
- cpu_reset:
  - 1 in WAIT, HDR and DATA.
  - Goes 0 on the cycle after load_done is asserted, so the processor's first fetch sees all words written.
- Fetch read:
  - One-cycle latency: code_word <= mem[code_addr[MEM_ADDR_BITS-1:0]] at each posedge while in RUN.
  - If code_addr >= DEPTH, code_word <= 0.
  - In WAIT/HDR/DATA, code_word <= 0.
  - Reads and writes never overlap, since reads are masked outside RUN.
- Counter wrap: the write address is MEM_ADDR_BITS+1 wide and saturates at DEPTH; it never wraps back into valid memory.
- Reset mid-load: returns to WAIT with cpu_reset = 1. Partially written memory is kept, but the system is not released until a full load completes.
- byte_valid while byte_ready = 0 (WAIT/RUN): the byte is ignored.

Test Plan:
- Reset, then idle 10 cycles -> cpu_reset = 1, byte_ready = 0, code_word = 0, load_done never pulses.
- load_start; header 03 00 00; words 0x00001, 0x3FFFF (bytes FF FF FF), 0x12345 (45 23 01) -> load_done one pulse after the 12th byte; cpu_reset falls the next cycle; code_addr 0,1,2 give 0x00001, 0x3FFFF, 0x12345 one cycle later; code_addr 3 returns stale memory; code_addr = DEPTH returns 0.
- Header 00 00 00 -> load_done pulse, RUN, no memory writes.
- MEM_ADDR_BITS=2, word count 5 -> all 15 data bytes accepted; overflow = 1 after the fifth word; mem[0..3] hold the first 4 words; the next load_start clears overflow.
- load_start after 4 DATA bytes -> back to HDR, byte index 0; the new image loads correctly and cpu_reset stays 1 throughout.
- reset asserted during DATA -> next cycle state WAIT, cpu_reset = 1, byte_ready = 0; a following full load succeeds.

Source files
------------

// File: rtl/code_memory_loader.sv
// rtl/code_memory_loader.sv - program memory with byte-stream image loader and processor reset hold
module code_memory_loader #(
  parameter int unsigned ADDR_SIZE     = 18,
  parameter int unsigned WORD_SIZE     = 18,
  parameter int unsigned MEM_ADDR_BITS = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] code_addr,
  output logic [WORD_SIZE-1:0] code_word,
  input  logic                 load_start,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 load_done,
  output logic                 overflow,
  output logic                 cpu_reset
);

  localparam int unsigned DEPTH = 1 << MEM_ADDR_BITS;
  localparam logic [MEM_ADDR_BITS:0] DEPTH_W = {1'b1, {MEM_ADDR_BITS{1'b0}}};
  localparam logic [MEM_ADDR_BITS:0] ONE_W   = {{MEM_ADDR_BITS{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_WAIT, S_HDR, S_DATA, S_RUN} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic [15:0]            lo_q, lo_d;
  logic [17:0]            count_q, count_d;
  logic [MEM_ADDR_BITS:0] waddr_q, waddr_d;
  logic                   overflow_q, overflow_d;
  logic                   load_done_q, load_done_d;
  logic                   cpu_reset_q, cpu_reset_d;
  logic [WORD_SIZE-1:0]   code_word_q, code_word_d;

  logic [WORD_SIZE-1:0]   mem [DEPTH];
  logic                   mem_we;
  logic                   xfer;
  logic                   addr_hi;
  logic [17:0]            full;

  assign byte_ready = (state_q == S_HDR) || (state_q == S_DATA);
  assign xfer       = byte_valid && byte_ready;
  // b2[7:2] carries no payload; only its two low bits complete the value
  assign full       = {byte_in[1:0], lo_q};
  assign addr_hi    = |code_addr[ADDR_SIZE-1:MEM_ADDR_BITS];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lo_d        = lo_q;
    count_d     = count_q;
    waddr_d     = waddr_q;
    overflow_d  = overflow_q;
    load_done_d = 1'b0;
    cpu_reset_d = 1'b1;
    mem_we      = 1'b0;

    if (load_start) begin
      state_d    = S_HDR;
      idx_d      = 2'd0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        S_HDR, S_DATA: begin
          if (xfer) begin
            if (idx_q == 2'd2) begin
              idx_d = 2'd0;
              if (state_q == S_HDR) begin
                if (full == 18'd0) begin
                  state_d     = S_RUN;
                  load_done_d = 1'b1;
                end else begin
                  count_d = full;
                  waddr_d = '0;
                  state_d = S_DATA;
                end
              end else begin
                if (waddr_q < DEPTH_W) mem_we = 1'b1;
                else                   overflow_d = 1'b1;
                // saturate so an oversized image never wraps into low memory
                if (waddr_q != DEPTH_W) waddr_d = waddr_q + ONE_W;
                count_d = count_q - 18'd1;
                if (count_q == 18'd1) begin
                  state_d     = S_RUN;
                  load_done_d = 1'b1;
                end
              end
            end else begin
              if (idx_q == 2'd0) lo_d[7:0]  = byte_in;
              else               lo_d[15:8] = byte_in;
              idx_d = idx_q + 2'd1;
            end
          end
        end
        // release one cycle after the done pulse so the first fetch sees the full image
        S_RUN:   cpu_reset_d = cpu_reset_q && !load_done_q;
        default: cpu_reset_d = 1'b1;
      endcase
    end

    if (state_q == S_RUN && !addr_hi) code_word_d = mem[code_addr[MEM_ADDR_BITS-1:0]];
    else                              code_word_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_WAIT;
      idx_q       <= 2'd0;
      lo_q        <= '0;
      count_q     <= '0;
      waddr_q     <= '0;
      overflow_q  <= 1'b0;
      load_done_q <= 1'b0;
      cpu_reset_q <= 1'b1;
      code_word_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lo_q        <= lo_d;
      count_q     <= count_d;
      waddr_q     <= waddr_d;
      overflow_q  <= overflow_d;
      load_done_q <= load_done_d;
      cpu_reset_q <= cpu_reset_d;
      code_word_q <= code_word_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we && !reset) mem[waddr_q[MEM_ADDR_BITS-1:0]] <= WORD_SIZE'(full);
  end

  assign code_word = code_word_q;
  assign load_done = load_done_q;
  assign overflow  = overflow_q;
  assign cpu_reset = cpu_reset_q;

endmodule

// File: tb/tb_code_memory_loader.sv
// tb/tb_code_memory_loader.sv - scoreboard bench driving a 1024-word and a 4-word loader in lockstep
module tb_code_memory_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [17:0] code_addr = '0;
  logic        load_start = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;

  logic [17:0] cw_b, cw_s;
  logic        br_b, br_s, ld_b, ld_s, ov_b, ov_s, cr_b, cr_s;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  code_memory_loader #(.ADDR_SIZE(18), .WORD_SIZE(18), .MEM_ADDR_BITS(10)) dut_big (
    .clock(clock), .reset(reset), .code_addr(code_addr), .code_word(cw_b),
    .load_start(load_start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(br_b), .load_done(ld_b), .overflow(ov_b), .cpu_reset(cr_b));

  code_memory_loader #(.ADDR_SIZE(18), .WORD_SIZE(18), .MEM_ADDR_BITS(2)) dut_small (
    .clock(clock), .reset(reset), .code_addr(code_addr), .code_word(cw_s),
    .load_start(load_start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(br_s), .load_done(ld_s), .overflow(ov_s), .cpu_reset(cr_s));

  logic [17:0] exp_b[$];
  logic [17:0] exp_s[$];
  logic [17:0] img[$];
  logic        rd_req = 1'b0;
  logic        rd_seen = 1'b0;
  bit          mon_en = 1'b0;
  bit          done_exp = 1'b0;
  bit          hold_exp = 1'b0;

  always @(posedge clock) rd_seen <= rd_req;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    logic [17:0] eb, es;
    if (mon_en) begin
      if (rd_seen) begin
        if (exp_b.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_empty: got read with no expected entry");
        end else begin
          eb = exp_b.pop_front();
          es = exp_s.pop_front();
          chk("code_word_big", 32'(cw_b), 32'(eb));
          chk("code_word_small", 32'(cw_s), 32'(es));
        end
      end
      if (!done_exp) chk("spurious_load_done", 32'({ld_b, ld_s}), 32'd0);
      if (hold_exp)  chk("cpu_reset_held", 32'({cr_b, cr_s}), 32'd3);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [17:0] w, input logic [5:0] junk);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte({junk, w[17:16]});
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    hold_exp   = 1'b1;
  endtask

  task automatic finish_load();
    done_exp = 1'b1;
    chk("load_done_pulse", 32'({ld_b, ld_s}), 32'd3);
    chk("cpu_reset_at_done", 32'({cr_b, cr_s}), 32'd3);
    tick();
    hold_exp = 1'b0;
    done_exp = 1'b0;
    chk("load_done_single", 32'({ld_b, ld_s}), 32'd0);
    chk("cpu_reset_released", 32'({cr_b, cr_s}), 32'd0);
  endtask

  task automatic do_load();
    start_load();
    send_word(18'(img.size()), 6'h00);
    foreach (img[i]) send_word(img[i], (i % 2 == 1) ? 6'h3F : 6'h00);
    finish_load();
  endtask

  task automatic rd(input logic [17:0] a, input logic [17:0] eb, input logic [17:0] es);
    code_addr = a;
    rd_req    = 1'b1;
    exp_b.push_back(eb);
    exp_s.push_back(es);
    tick();
  endtask

  task automatic rd_drain();
    rd_req = 1'b0;
    tick();
    tick();
  endtask

  localparam logic [17:0] A0 = 18'h0ABCD, A1 = 18'h15555, A2 = 18'h2AAAA,
                          A3 = 18'h00F0F, A4 = 18'h3C3C3;

  initial begin
    tick();
    tick();
    reset = 1'b0;
    mon_en = 1'b1;
    chk("reset_byte_ready", 32'({br_b, br_s}), 32'd0);
    chk("reset_cpu_reset", 32'({cr_b, cr_s}), 32'd3);
    chk("reset_overflow", 32'({ov_b, ov_s}), 32'd0);
    chk("reset_code_word", 32'({cw_b, cw_s}), 32'd0);

    // idle in WAIT with stray bytes offered; reads stay masked
    byte_in = 8'h55;
    byte_valid = 1'b1;
    for (int i = 0; i < 10; i++) rd(18'(i), 18'h0, 18'h0);
    byte_valid = 1'b0;
    rd_drain();
    chk("idle_byte_ready", 32'({br_b, br_s}), 32'd0);

    // five-word image: small instance overflows on the fifth word
    start_load();
    chk("hdr_byte_ready", 32'({br_b, br_s}), 32'd3);
    send_word(18'd5, 6'h00);
    send_word(A0, 6'h00);
    send_word(A1, 6'h3F);
    send_word(A2, 6'h00);
    send_word(A3, 6'h3F);
    chk("overflow_before_5th", 32'({ov_b, ov_s}), 32'd0);
    send_word(A4, 6'h15);
    chk("overflow_after_5th", 32'({ov_b, ov_s}), 32'd1);
    finish_load();
    rd(18'd0, A0, A0);
    rd(18'd1, A1, A1);
    rd(18'd2, A2, A2);
    rd(18'd3, A3, A3);
    rd(18'd4, A4, 18'h0);
    rd_drain();
    chk("overflow_sticky_run", 32'({ov_b, ov_s}), 32'd1);

    // aborted load: header plus four data bytes, then restart
    start_load();
    chk("overflow_cleared", 32'({ov_b, ov_s}), 32'd0);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    img = '{18'h00001, 18'h3FFFF, 18'h12345};
    do_load();
    rd(18'd0, 18'h00001, 18'h00001);
    rd(18'd1, 18'h3FFFF, 18'h3FFFF);
    rd(18'd2, 18'h12345, 18'h12345);
    rd(18'd3, A3, A3);
    rd(18'd4, A4, 18'h0);
    rd(18'd1024, 18'h0, 18'h0);
    rd_drain();

    // empty image: done pulse, nothing rewritten
    img = {};
    do_load();
    rd(18'd0, 18'h00001, 18'h00001);
    rd(18'd2, 18'h12345, 18'h12345);
    rd_drain();

    // bytes offered in RUN are ignored
    chk("run_byte_ready", 32'({br_b, br_s}), 32'd0);
    send_byte(8'h99);
    send_byte(8'h88);
    send_byte(8'h77);
    rd(18'd0, 18'h00001, 18'h00001);
    rd(18'd1, 18'h3FFFF, 18'h3FFFF);
    rd_drain();

    // reset in the middle of DATA
    start_load();
    send_word(18'd2, 6'h00);
    send_byte(8'h77);
    reset = 1'b1;
    tick();
    chk("midreset_byte_ready", 32'({br_b, br_s}), 32'd0);
    chk("midreset_cpu_reset", 32'({cr_b, cr_s}), 32'd3);
    chk("midreset_code_word", 32'({cw_b, cw_s}), 32'd0);
    reset = 1'b0;
    tick();
    chk("after_reset_byte_ready", 32'({br_b, br_s}), 32'd0);
    img = '{18'h2468A, 18'h13579};
    do_load();
    rd(18'd0, 18'h2468A, 18'h2468A);
    rd(18'd1, 18'h13579, 18'h13579);
    rd(18'd2, 18'h12345, 18'h12345);
    rd_drain();

    chk("scoreboard_drained", 32'(exp_b.size()), 32'd0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
